// File: rtl/cfs_md_rx_master.sv
// cfs_md_rx_master
//   MD initiator that takes commands from a 2-entry FIFO and drives them onto
//   the MD receive interface. Each transfer completes when the responder
//   returns md_rx_ready. The block counts good and errored completions in
//   saturating counters. An optional idle gap can be enforced between transfers.
//
// Ports
//   md_rx_clk     clock for all logic
//   preset_n      asynchronous active-low reset
//   cnt_clr       synchronous clear of cnt_sent / cnt_err (wins over increment)
//   cmd_valid     command push request
//   cmd_data      command payload
//   cmd_offset    command offset
//   cmd_size      command size
//   cmd_ready     FIFO has room (registered occupancy < 2)
//   md_rx_valid   transfer in progress
//   md_rx_data    transfer payload, held while md_rx_valid is low
//   md_rx_offset  transfer offset, held while md_rx_valid is low
//   md_rx_size    transfer size, held while md_rx_valid is low
//   md_rx_ready   responder completes the transfer
//   md_rx_err     error response, sampled only on completion
//   cnt_sent      saturating count of error-free completions
//   cnt_err       saturating count of errored completions
//   busy          FSM not idle or FIFO not empty

module cfs_md_rx_master #(
  parameter  int ALGN_DATA_WIDTH = 32,
  parameter  int CNT_WIDTH       = 8,
  parameter  int GAP_CYCLES      = 0,
  localparam int OFFSET_W        = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8),
  localparam int SIZE_W          = $clog2(ALGN_DATA_WIDTH / 8) + 1
) (
  input  logic                       md_rx_clk,
  input  logic                       preset_n,
  input  logic                       cnt_clr,
  input  logic                       cmd_valid,
  input  logic [ALGN_DATA_WIDTH-1:0] cmd_data,
  input  logic [OFFSET_W-1:0]        cmd_offset,
  input  logic [SIZE_W-1:0]          cmd_size,
  output logic                       cmd_ready,
  output logic                       md_rx_valid,
  output logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
  output logic [OFFSET_W-1:0]        md_rx_offset,
  output logic [SIZE_W-1:0]          md_rx_size,
  input  logic                       md_rx_ready,
  input  logic                       md_rx_err,
  output logic [CNT_WIDTH-1:0]       cnt_sent,
  output logic [CNT_WIDTH-1:0]       cnt_err,
  output logic                       busy
);

  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StGap
  } state_e;

  state_e                     r_state;
  state_e                     w_state_nxt;

  logic [ALGN_DATA_WIDTH-1:0] r_fifo_data   [2];
  logic [OFFSET_W-1:0]        r_fifo_offset [2];
  logic [SIZE_W-1:0]          r_fifo_size   [2];
  logic                       r_wr_ptr;
  logic                       r_rd_ptr;
  logic [1:0]                 r_occ;

  logic                       r_md_valid;
  logic [ALGN_DATA_WIDTH-1:0] r_md_data;
  logic [OFFSET_W-1:0]        r_md_offset;
  logic [SIZE_W-1:0]          r_md_size;
  logic [GAP_W-1:0]           r_gap_cnt;
  logic [CNT_WIDTH-1:0]       r_cnt_sent;
  logic [CNT_WIDTH-1:0]       r_cnt_err;

  logic                       w_push;
  logic                       w_load;
  logic                       w_done;
  logic                       w_clr_valid;
  logic                       w_gap_load;
  logic                       w_gap_dec;
  logic                       w_fifo_nempty;

  assign cmd_ready     = (r_occ < 2'd2);
  assign w_push        = cmd_valid & cmd_ready;
  assign w_fifo_nempty = (r_occ != 2'd0);
  // md_rx_err is only meaningful on a valid & ready edge
  assign w_done        = r_md_valid & md_rx_ready;

  // Next-state / control
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clr_valid = 1'b0;
    w_gap_load  = 1'b0;
    w_gap_dec   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_fifo_nempty) begin
          w_load      = 1'b1;
          w_state_nxt = StDrive;
        end
      end
      StDrive: begin
        if (w_done) begin
          if (GAP_CYCLES == 0) begin
            if (w_fifo_nempty) begin
              // back-to-back: next command replaces the finished one, valid stays high
              w_load = 1'b1;
            end else begin
              w_clr_valid = 1'b1;
              w_state_nxt = StIdle;
            end
          end else begin
            w_clr_valid = 1'b1;
            w_gap_load  = 1'b1;
            w_state_nxt = StGap;
          end
        end
      end
      StGap: begin
        w_gap_dec = (r_gap_cnt != '0);
        // last idle cycle: leave on this edge so the gap is exactly GAP_CYCLES long
        if (r_gap_cnt <= GAP_W'(1)) begin
          if (w_fifo_nempty) begin
            w_load      = 1'b1;
            w_state_nxt = StDrive;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge md_rx_clk or negedge preset_n) begin
    if (!preset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command FIFO
  always_ff @(posedge md_rx_clk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i]   <= '0;
        r_fifo_offset[i] <= '0;
        r_fifo_size[i]   <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr]   <= cmd_data;
        r_fifo_offset[r_wr_ptr] <= cmd_offset;
        r_fifo_size[r_wr_ptr]   <= cmd_size;
        r_wr_ptr                <= ~r_wr_ptr;
      end
      if (w_load) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_load};
    end
  end

  // MD output registers and gap counter
  always_ff @(posedge md_rx_clk or negedge preset_n) begin
    if (!preset_n) begin
      r_md_valid  <= 1'b0;
      r_md_data   <= '0;
      r_md_offset <= '0;
      r_md_size   <= '0;
      r_gap_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_md_valid  <= 1'b1;
        r_md_data   <= r_fifo_data[r_rd_ptr];
        r_md_offset <= r_fifo_offset[r_rd_ptr];
        r_md_size   <= r_fifo_size[r_rd_ptr];
      end else if (w_clr_valid) begin
        r_md_valid <= 1'b0;
      end
      if (w_gap_load) begin
        r_gap_cnt <= GAP_W'(GAP_CYCLES);
      end else if (w_gap_dec) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  // Saturating status counters; clear wins over a same-edge increment
  always_ff @(posedge md_rx_clk or negedge preset_n) begin
    if (!preset_n) begin
      r_cnt_sent <= '0;
      r_cnt_err  <= '0;
    end else if (cnt_clr) begin
      r_cnt_sent <= '0;
      r_cnt_err  <= '0;
    end else if (w_done) begin
      if (md_rx_err) begin
        if (r_cnt_err != '1) begin
          r_cnt_err <= r_cnt_err + 1'b1;
        end
      end else if (r_cnt_sent != '1) begin
        r_cnt_sent <= r_cnt_sent + 1'b1;
      end
    end
  end

  assign md_rx_valid  = r_md_valid;
  assign md_rx_data   = r_md_data;
  assign md_rx_offset = r_md_offset;
  assign md_rx_size   = r_md_size;
  assign cnt_sent     = r_cnt_sent;
  assign cnt_err      = r_cnt_err;
  assign busy         = (r_state != StIdle) || w_fifo_nempty;

endmodule
